// File: rtl/cnn_acc_pkg.sv
// Shared widths, FSM encoding and requantization helpers for the conv2
// accumulate/requantize stage.
package cnn_acc_pkg;

  localparam int PROD_W = 22;
  localparam int ACC_W  = 32;
  localparam int OUT_W  = 8;

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_RQ  = 1'b1
  } state_e;

  // Half an LSB of the shifted result, added before the arithmetic shift.
  function automatic int round_const(input int shift);
    return 1 << (shift - 1);
  endfunction

  function automatic int clip_max(input int out_w);
    return (1 << (out_w - 1)) - 1;
  endfunction

  function automatic int clip_min(input int out_w);
    return -(1 << (out_w - 1));
  endfunction

  // bias + KLEN products must fit the accumulator without wrapping.
  function automatic bit klen_legal(input int klen, input int acc_w, input int prod_w);
    return (klen >= 1) && (klen <= (1 << (acc_w - prod_w - 1)));
  endfunction

endpackage

// File: rtl/cnn_conv_acc_requant_rq.sv
// Combinational requantizer: round-half-up, arithmetic shift, saturate to
// OUT_W and optional ReLU. sat_o reports clipping to the OUT_W range.
module cnn_requant_sat #(
  parameter int ACC_W = 32,
  parameter int SHIFT = 6,
  parameter int OUT_W = 8,
  parameter int RELU  = 1
) (
  input  logic signed [ACC_W-1:0] sum_i,
  output logic signed [OUT_W-1:0] data_o,
  output logic                    sat_o
);
  import cnn_acc_pkg::*;

  // One guard bit so the rounding add cannot wrap near the accumulator limit.
  localparam int EXT_W = ACC_W + 1;
  localparam logic signed [EXT_W-1:0] RND  = EXT_W'(round_const(SHIFT));
  localparam logic signed [EXT_W-1:0] MAXV = EXT_W'(clip_max(OUT_W));
  localparam logic signed [EXT_W-1:0] MINV = EXT_W'(clip_min(OUT_W));

  logic signed [EXT_W-1:0] rnd_s;
  logic signed [EXT_W-1:0] shr_s;
  logic signed [EXT_W-1:0] clip_s;

  always_comb begin
    rnd_s  = EXT_W'(sum_i) + RND;
    shr_s  = rnd_s >>> SHIFT;
    clip_s = shr_s;
    sat_o  = 1'b0;
    if (shr_s > MAXV) begin
      clip_s = MAXV;
      sat_o  = 1'b1;
    end else if (shr_s < MINV) begin
      clip_s = MINV;
      sat_o  = 1'b1;
    end
    data_o = clip_s[OUT_W-1:0];
    if ((RELU != 0) && (clip_s < 0)) begin
      data_o = '0;
    end
  end

endmodule

// File: rtl/cnn_conv_acc_requant.sv
// Accumulates KLEN signed products plus a per-window bias, then requantizes
// the window sum into a held AXI-stream style output register.
module cnn_conv_acc_requant #(
  parameter int PROD_W = cnn_acc_pkg::PROD_W,
  parameter int ACC_W  = cnn_acc_pkg::ACC_W,
  parameter int KLEN   = 9,
  parameter int SHIFT  = 6,
  parameter int OUT_W  = cnn_acc_pkg::OUT_W,
  parameter int RELU   = 1
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic signed [PROD_W-1:0] prod_tdata,
  input  logic                     prod_tvalid,
  output logic                     prod_tready,
  input  logic signed [PROD_W-1:0] bias,
  output logic signed [OUT_W-1:0]  out_tdata,
  output logic                     out_tvalid,
  input  logic                     out_tready,
  output logic                     sat_flag
);
  import cnn_acc_pkg::*;

  if (!klen_legal(KLEN, ACC_W, PROD_W)) begin : g_bad_klen
    $error("KLEN outside 1..2^(ACC_W-PROD_W-1)");
  end
  if (SHIFT < 1) begin : g_bad_shift
    $error("SHIFT must be at least 1");
  end

  localparam int CNT_W = (KLEN > 1) ? $clog2(KLEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KLEN - 1);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  sum_q, sum_d;
  logic signed [OUT_W-1:0]  out_data_q, out_data_d;
  logic                     out_vld_q, out_vld_d;
  logic                     sat_q, sat_d;
  logic                     ready_q, ready_d;

  logic signed [ACC_W-1:0]  base;
  logic signed [ACC_W-1:0]  total;
  logic signed [OUT_W-1:0]  rq_data;
  logic                     rq_sat;
  logic                     accept;

  cnn_requant_sat #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W),
    .RELU  (RELU)
  ) u_rq (
    .sum_i  (sum_q),
    .data_o (rq_data),
    .sat_o  (rq_sat)
  );

  // ready_q mirrors the next state so prod_tready never sees out_tready.
  assign accept      = prod_tvalid && ready_q;
  assign prod_tready = ready_q;
  assign out_tdata   = out_data_q;
  assign out_tvalid  = out_vld_q;
  assign sat_flag    = sat_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    sum_d      = sum_q;
    out_data_d = out_data_q;
    out_vld_d  = out_vld_q;
    sat_d      = sat_q;

    base  = (cnt_q == '0) ? ACC_W'(bias) : acc_q;
    total = base + ACC_W'(prod_tdata);

    if (accept) begin
      if (cnt_q == CNT_LAST) begin
        sum_d   = total;
        cnt_d   = '0;
        state_d = ST_RQ;
      end else begin
        acc_d = total;
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (out_vld_q && out_tready) begin
      out_vld_d = 1'b0;
    end
    // A drain and a load in the same cycle keep out_tvalid high with no bubble.
    if ((state_q == ST_RQ) && (!out_vld_q || out_tready)) begin
      out_data_d = rq_data;
      sat_d      = rq_sat;
      out_vld_d  = 1'b1;
      state_d    = ST_ACC;
    end

    ready_d = (state_d == ST_ACC);
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q    <= ST_ACC;
      cnt_q      <= '0;
      acc_q      <= '0;
      sum_q      <= '0;
      out_data_q <= '0;
      out_vld_q  <= 1'b0;
      sat_q      <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      sum_q      <= sum_d;
      out_data_q <= out_data_d;
      out_vld_q  <= out_vld_d;
      sat_q      <= sat_d;
      ready_q    <= ready_d;
    end
  end

endmodule
